// File: rtl/nibble_serial_addsub_if.sv
// ============================================================================
// Module      : nibble_serial_addsub_if
// Description : Operand/result handshake bundle for nibble_serial_addsub.
//               zero/ovf exist only when STATUS_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef STATUS_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    // master drives operands and consumes results; slave is the adder itself
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, cout
`ifdef STATUS_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, cout
`ifdef STATUS_FLAGS_EN
        , output zero, ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
// ============================================================================
// Module      : nibble_serial_addsub
// Description : WIDTH-bit add/subtract computed one 4-bit CLA slice per clock,
//               valid/ready on both sides. Optional macro: STATUS_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] areg_q,   areg_d;
    logic [WIDTH-1:0] breg_q,   breg_d;
    logic             carry_q,  carry_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
`ifdef STATUS_FLAGS_EN
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
`endif

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] cy;
    logic [3:0] sum;
    logic       last_nib;

    assign nib_a    = areg_q[4*idx_q +: 4];
    assign nib_b    = breg_q[4*idx_q +: 4];
    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // 4-bit carry-look-ahead slice; cy[3] is the carry into the slice MSB
    always_comb begin
        gen   = nib_a & nib_b;
        prop  = nib_a ^ nib_b;
        cy[0] = carry_q;
        cy[1] = gen[0] | (prop[0] & cy[0]);
        cy[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cy[0]);
        cy[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cy[0]);
        cy[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0])
              | (prop[3] & prop[2] & prop[1] & prop[0] & cy[0]);
        sum   = prop ^ cy[3:0];
    end

    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef STATUS_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d  = S_CALC;
                    areg_d   = bus.a;
                    breg_d   = bus.b ^ {WIDTH{bus.op}};
                    carry_d  = bus.op;
                    idx_d    = '0;
                    result_d = '0;
`ifdef STATUS_FLAGS_EN
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_CALC: begin
                result_d[4*idx_q +: 4] = sum;
                carry_d                = cy[4];
                idx_d                  = idx_q + 1'b1;
                if (last_nib) begin
                    cout_d  = cy[4];
                    state_d = S_DONE;
`ifdef STATUS_FLAGS_EN
                    zero_d  = (result_d == '0);
                    ovf_d   = cy[3] ^ cy[4];
`endif
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            areg_q   <= '0;
            breg_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef STATUS_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef STATUS_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
`ifdef STATUS_FLAGS_EN
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
`endif

endmodule

`default_nettype wire
